// File: rtl/rot_pkg.sv
// rtl/rot_pkg.sv - shared types and default widths for the rotate-step controller
package rot_pkg;

    localparam int ROT_WIDTH = 16;
    localparam int ROT_DIV_W = 16;
    localparam int ROT_CNT_W = 8;

    localparam logic ROT_DIR_LEFT  = 1'b0;
    localparam logic ROT_DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } rot_state_t;

endpackage

// File: rtl/rot_prescaler.sv
// rtl/rot_prescaler.sv - step-rate prescaler: counts 0..div, ticks at div and wraps to 0
module rot_prescaler
    import rot_pkg::*;
#(
    parameter int DIV_W = ROT_DIV_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] count_q, count_d;

    assign tick_o = (count_q == div_i);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tick_o ? '0 : count_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rot_step_ctrl.sv
// rtl/rot_step_ctrl.sv - seed-load then paced rotate-step sequencer for the rotator stage
// Optional ROT_STEP_CONT_EN: steps=0 runs continuously until abort.
module rot_step_ctrl
    import rot_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH,
    parameter int DIV_W = ROT_DIV_W,
    parameter int CNT_W = ROT_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             dir_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [CNT_W-1:0] steps_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             load_o,
    output logic [WIDTH-1:0] load_val_o,
    output logic             step_en_o,
    output logic             step_dir_o,
    output logic [CNT_W-1:0] steps_left_o
);

    rot_state_t       state_q, state_d;
    logic [WIDTH-1:0] load_val_q, load_val_d;
    logic             dir_q, dir_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] steps_left_q, steps_left_d;
    logic             cont_q, cont_d;
    logic             busy_q, done_q, load_q, step_en_q;
    logic             step_d;
    logic             pre_clr, pre_en, tick;

    rot_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (pre_clr),
        .en_i   (pre_en),
        .div_i  (div_q),
        .tick_o (tick)
    );

    // Step decisions are made at the edge so step_en is registered; the final
    // step's enable cycle is still RUN (steps_left==0), then DONE follows.
    always_comb begin
        state_d      = state_q;
        load_val_d   = load_val_q;
        dir_d        = dir_q;
        div_d        = div_q;
        steps_left_d = steps_left_q;
        cont_d       = cont_q;
        step_d       = 1'b0;
        pre_clr      = 1'b0;
        pre_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    load_val_d   = seed_i;
                    dir_d        = dir_i;
                    div_d        = div_i;
                    steps_left_d = steps_i;
`ifdef ROT_STEP_CONT_EN
                    cont_d       = (steps_i == '0);
`else
                    cont_d       = 1'b0;
`endif
                    pre_clr      = 1'b1;
                    state_d      = LOAD;
                end
            end
            LOAD, RUN: begin
                pre_en = 1'b1;
                if (abort_i) begin
                    state_d = IDLE;
                end else if (tick && (cont_q || steps_left_q != '0)) begin
                    step_d  = 1'b1;
                    state_d = RUN;
                    if (steps_left_q != '0) begin
                        steps_left_d = steps_left_q - CNT_W'(1);
                    end
                end else if (!cont_q && steps_left_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            load_val_q   <= '0;
            dir_q        <= ROT_DIR_LEFT;
            div_q        <= '0;
            steps_left_q <= '0;
            cont_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_q       <= 1'b0;
            step_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_val_q   <= load_val_d;
            dir_q        <= dir_d;
            div_q        <= div_d;
            steps_left_q <= steps_left_d;
            cont_q       <= cont_d;
            busy_q       <= (state_d == LOAD) || (state_d == RUN);
            done_q       <= (state_d == DONE);
            load_q       <= (state_d == LOAD);
            step_en_q    <= step_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign load_o       = load_q;
    assign load_val_o   = load_val_q;
    assign step_en_o    = step_en_q;
    assign step_dir_o   = dir_q;
    assign steps_left_o = steps_left_q;

endmodule

// File: tb/tb_rot_step_ctrl.sv
// tb/tb_rot_step_ctrl.sv - directed self-checking bench for rot_step_ctrl
module tb_rot_step_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] seed_i = '0;
    logic        dir_i = 1'b0;
    logic [15:0] div_i = '0;
    logic [7:0]  steps_i = '0;
    logic        abort_i = 1'b0;
    logic        busy_o, done_o, load_o, step_en_o, step_dir_o;
    logic [15:0] load_val_o;
    logic [7:0]  steps_left_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] load_m, step_m, done_m, busy_m;
    logic [7:0]  steps_first;

    rot_step_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .seed_i       (seed_i),
        .dir_i        (dir_i),
        .div_i        (div_i),
        .steps_i      (steps_i),
        .abort_i      (abort_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .load_o       (load_o),
        .load_val_o   (load_val_o),
        .step_en_o    (step_en_o),
        .step_dir_o   (step_dir_o),
        .steps_left_o (steps_left_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives start so it is sampled at the next rising edge (edge N).
    task automatic start_pulse(input logic [15:0] seed, input logic dir,
                               input logic [15:0] div, input logic [7:0] steps);
        @(negedge clk_i);
        seed_i  = seed;
        dir_i   = dir;
        div_i   = div;
        steps_i = steps;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    // Bit k of each mask is the output value in cycle N+k; abort/start are raised
    // during cycle N+k so they are sampled at edge N+k.
    task automatic trace(input int len, input int abort_at, input int start_at);
        load_m = '0;
        step_m = '0;
        done_m = '0;
        busy_m = '0;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk_i);
            load_m[k] = load_o;
            step_m[k] = step_en_o;
            done_m[k] = done_o;
            busy_m[k] = busy_o;
            if (k == 1) steps_first = steps_left_o;
            abort_i = (k == abort_at);
            start_i = (k == start_at);
            if (k == start_at) begin
                seed_i  = 16'hF000;
                dir_i   = 1'b1;
                div_i   = 16'd0;
                steps_i = 8'd7;
            end
        end
        @(negedge clk_i);
        abort_i = 1'b0;
        start_i = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_outputs", {busy_o, done_o, load_o, step_en_o, step_dir_o, steps_left_o, load_val_o}, '0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // div=3, steps=4, rotate left
        start_pulse(16'h0001, 1'b0, 16'd3, 8'd4);
        trace(22, 0, 0);
        check("t1_load", load_m, 64'h2);
        check("t1_steps", step_m, 64'h22220);
        check("t1_done", done_m, 64'h40000);
        check("t1_busy", busy_m, 64'h3FFFE);
        check("t1_load_val", 64'(load_val_o), 64'h0001);
        check("t1_steps_first", 64'(steps_first), 64'd4);
        check("t1_steps_last", 64'(steps_left_o), 64'd0);
        check("t1_dir", 64'(step_dir_o), 64'd0);

        // div=0, steps=3, rotate right; start during DONE is ignored
        start_pulse(16'hA5C3, 1'b1, 16'd0, 8'd3);
        trace(10, 0, 5);
        check("t2_load", load_m, 64'h2);
        check("t2_steps", step_m, 64'h1C);
        check("t2_done", done_m, 64'h20);
        check("t2_busy", busy_m, 64'h1E);
        check("t2_dir", 64'(step_dir_o), 64'd1);
        check("t2_load_val", 64'(load_val_o), 64'hA5C3);

        // steps=0
`ifdef ROT_STEP_CONT_EN
        start_pulse(16'h0F0F, 1'b0, 16'd2, 8'd0);
        trace(16, 11, 0);
        check("t3_load", load_m, 64'h2);
        check("t3_steps", step_m, 64'h490);
        check("t3_done", done_m, 64'h0);
        check("t3_busy", busy_m, 64'hFFE);
        check("t3_steps_left", 64'(steps_left_o), 64'd0);
`else
        start_pulse(16'h0F0F, 1'b0, 16'd2, 8'd0);
        trace(8, 0, 0);
        check("t3_load", load_m, 64'h2);
        check("t3_steps", step_m, 64'h0);
        check("t3_done", done_m, 64'h4);
        check("t3_busy", busy_m, 64'h2);
`endif

        // abort coincident with the final step decision
        start_pulse(16'h00FF, 1'b0, 16'd1, 8'd2);
        trace(10, 4, 0);
        check("t4_load", load_m, 64'h2);
        check("t4_steps", step_m, 64'h8);
        check("t4_done", done_m, 64'h0);
        check("t4_busy", busy_m, 64'h1E);
        check("t4_steps_left", 64'(steps_left_o), 64'd1);

        // start while busy is ignored
        start_pulse(16'h1234, 1'b0, 16'd1, 8'd2);
        trace(12, 0, 3);
        check("t5_load", load_m, 64'h2);
        check("t5_steps", step_m, 64'h28);
        check("t5_done", done_m, 64'h40);
        check("t5_busy", busy_m, 64'h3E);
        check("t5_load_val", 64'(load_val_o), 64'h1234);
        check("t5_dir", 64'(step_dir_o), 64'd0);

        // asynchronous reset mid-run
        start_pulse(16'h8001, 1'b1, 16'd3, 8'd4);
        repeat (3) @(posedge clk_i);
        #2;
        check("t6_busy_before", 64'(busy_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        check("t6_async_zero", {busy_o, done_o, load_o, step_en_o, step_dir_o, steps_left_o, load_val_o}, '0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        trace(10, 0, 0);
        check("t6_busy_after", busy_m, 64'h0);
        check("t6_steps_after", step_m | done_m | load_m, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
